// File: rtl/accum_mc.sv
// rtl/accum_mc.sv - multi-channel FMULT/ACCUM term accumulator
// Per-channel partial sums with single-cycle read-modify-write and optional saturation.
module accum_mc #(
  parameter int WIDTH  = 16,
  parameter int NCH    = 32,
  parameter int CH_W   = 5,
  parameter int NTERMS = 8,
  parameter int SAT    = 0
) (
  input  logic             reset,
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_start,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [WIDTH-1:0] W,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] S,
  output logic             out_ovf,
  output logic             seq_err
);

  localparam int CNT_W = (NTERMS > 1) ? $clog2(NTERMS) : 1;
  localparam logic [CNT_W:0]   LAST_CNT = (CNT_W + 1)'(NTERMS);
  localparam logic [CNT_W:0]   ONE_CNT  = (CNT_W + 1)'(1);
  localparam logic [CH_W:0]    NCH_LIM  = (CH_W + 1)'(NCH);
  localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MAX  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc   [NCH];
  logic [CNT_W-1:0] cnt   [NCH];
  logic             ovf_r [NCH];

  logic             accept;
  logic             ch_ok;
  logic [CH_W-1:0]  idx;
  logic [WIDTH-1:0] cur_acc;
  logic [CNT_W-1:0] cur_cnt;
  logic             cur_ovf;
  logic             is_idle;
  logic             do_load;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] nxt_acc;
  logic             nxt_ovf;
  logic [CNT_W:0]   nxt_cnt;
  logic             done;
  logic             proto_err;

  assign accept = in_valid & ~clear;
  assign ch_ok  = ({1'b0, in_ch} < NCH_LIM);
  // Out-of-range channels are steered to 0 so the array read stays in bounds.
  assign idx    = ch_ok ? in_ch : '0;

  always_comb begin
    cur_acc   = acc[idx];
    cur_cnt   = cnt[idx];
    cur_ovf   = ovf_r[idx];
    is_idle   = (cur_cnt == '0);
    do_load   = in_start | is_idle;
    sum       = cur_acc + W;
    add_ovf   = (cur_acc[WIDTH-1] == W[WIDTH-1]) && (sum[WIDTH-1] != cur_acc[WIDTH-1]);
    nxt_acc   = sum;
    nxt_ovf   = cur_ovf | add_ovf;
    nxt_cnt   = {1'b0, cur_cnt} + ONE_CNT;
    if (do_load) begin
      nxt_acc = W;
      nxt_ovf = 1'b0;
      nxt_cnt = ONE_CNT;
    end else if ((SAT != 0) && add_ovf) begin
      nxt_acc = cur_acc[WIDTH-1] ? NEG_MAX : POS_MAX;
    end
    done      = (nxt_cnt == LAST_CNT);
    proto_err = ~ch_ok | (in_start & ~is_idle) | (~in_start & is_idle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i]   <= '0;
        cnt[i]   <= '0;
        ovf_r[i] <= 1'b0;
      end
    end else if (clear) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i]   <= '0;
        cnt[i]   <= '0;
        ovf_r[i] <= 1'b0;
      end
    end else if (accept && ch_ok) begin
      if (done) begin
        acc[idx]   <= '0;
        cnt[idx]   <= '0;
        ovf_r[idx] <= 1'b0;
      end else begin
        acc[idx]   <= nxt_acc;
        cnt[idx]   <= nxt_cnt[CNT_W-1:0];
        ovf_r[idx] <= nxt_ovf;
      end
    end
  end

  // Result fields hold their last completed value between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      S         <= '0;
      out_ovf   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      out_valid <= accept & ch_ok & done;
      seq_err   <= accept & proto_err;
      if (accept && ch_ok && done) begin
        out_ch  <= idx;
        S       <= nxt_acc;
        out_ovf <= nxt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_accum_mc.sv
// tb/tb_accum_mc.sv - randomized self-checking bench for accum_mc
// Four configurations share one stimulus stream and an integer-arithmetic reference model.
module tb_accum_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_start = 1'b0;
  logic [4:0]  in_ch = '0;
  logic [15:0] w = '0;

  logic        o_valid [4];
  logic        o_ovf   [4];
  logic        o_err   [4];
  logic [4:0]  o_ch    [4];
  logic [15:0] o_s     [4];

  always #5 clk = ~clk;

  accum_mc #(.WIDTH(16), .NCH(32), .CH_W(5), .NTERMS(8), .SAT(0)) u0 (
    .reset(reset), .clk(clk), .clear(clear), .in_valid(in_valid), .in_start(in_start),
    .in_ch(in_ch), .W(w), .out_valid(o_valid[0]), .out_ch(o_ch[0]), .S(o_s[0]),
    .out_ovf(o_ovf[0]), .seq_err(o_err[0]));
  accum_mc #(.WIDTH(16), .NCH(32), .CH_W(5), .NTERMS(8), .SAT(1)) u1 (
    .reset(reset), .clk(clk), .clear(clear), .in_valid(in_valid), .in_start(in_start),
    .in_ch(in_ch), .W(w), .out_valid(o_valid[1]), .out_ch(o_ch[1]), .S(o_s[1]),
    .out_ovf(o_ovf[1]), .seq_err(o_err[1]));
  accum_mc #(.WIDTH(16), .NCH(32), .CH_W(5), .NTERMS(1), .SAT(1)) u2 (
    .reset(reset), .clk(clk), .clear(clear), .in_valid(in_valid), .in_start(in_start),
    .in_ch(in_ch), .W(w), .out_valid(o_valid[2]), .out_ch(o_ch[2]), .S(o_s[2]),
    .out_ovf(o_ovf[2]), .seq_err(o_err[2]));
  accum_mc #(.WIDTH(16), .NCH(20), .CH_W(5), .NTERMS(3), .SAT(0)) u3 (
    .reset(reset), .clk(clk), .clear(clear), .in_valid(in_valid), .in_start(in_start),
    .in_ch(in_ch), .W(w), .out_valid(o_valid[3]), .out_ch(o_ch[3]), .S(o_s[3]),
    .out_ovf(o_ovf[3]), .seq_err(o_err[3]));

  int cfg_nch [4] = '{32, 32, 32, 20};
  int cfg_nt  [4] = '{8, 8, 1, 3};
  int cfg_sat [4] = '{0, 1, 1, 0};

  // Model keeps partial sums as plain signed integers in [-32768, 32767].
  int m_acc [4][32];
  int m_cnt [4][32];
  bit m_ovf [4][32];
  bit e_valid [4];
  bit e_err   [4];
  bit e_ovf   [4];
  int e_ch    [4];
  int e_s     [4];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 32; c++) begin
        m_acc[i][c] = 0;
        m_cnt[i][c] = 0;
        m_ovf[i][c] = 1'b0;
      end
      e_valid[i] = 1'b0;
      e_err[i]   = 1'b0;
      e_ovf[i]   = 1'b0;
      e_ch[i]    = 0;
      e_s[i]     = 0;
    end
  endtask

  task automatic model_step(input int i, input bit v, input bit st, input int ch,
                            input int wv, input bit clr);
    int  r;
    bit  ov;
    bit  idle;
    e_valid[i] = 1'b0;
    e_err[i]   = 1'b0;
    if (clr) begin
      for (int c = 0; c < 32; c++) begin
        m_acc[i][c] = 0;
        m_cnt[i][c] = 0;
        m_ovf[i][c] = 1'b0;
      end
    end else if (v) begin
      if (ch >= cfg_nch[i]) begin
        e_err[i] = 1'b1;
      end else begin
        idle = (m_cnt[i][ch] == 0);
        if ((st && !idle) || (!st && idle)) e_err[i] = 1'b1;
        if (st || idle) begin
          m_acc[i][ch] = wv;
          m_ovf[i][ch] = 1'b0;
          m_cnt[i][ch] = 1;
        end else begin
          r  = m_acc[i][ch] + wv;
          ov = (r > 32767) || (r < -32768);
          if (ov) begin
            if (cfg_sat[i] != 0) r = (r > 32767) ? 32767 : -32768;
            else                 r = (r > 32767) ? r - 65536 : r + 65536;
          end
          m_acc[i][ch] = r;
          m_ovf[i][ch] = m_ovf[i][ch] | ov;
          m_cnt[i][ch] = m_cnt[i][ch] + 1;
        end
        if (m_cnt[i][ch] == cfg_nt[i]) begin
          e_valid[i]   = 1'b1;
          e_ch[i]      = ch;
          e_s[i]       = m_acc[i][ch] & 32'hFFFF;
          e_ovf[i]     = m_ovf[i][ch];
          m_acc[i][ch] = 0;
          m_cnt[i][ch] = 0;
          m_ovf[i][ch] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d out_valid", i), 32'(o_valid[i]), 32'(e_valid[i]));
      check($sformatf("u%0d seq_err", i),   32'(o_err[i]),   32'(e_err[i]));
      check($sformatf("u%0d S", i),         32'(o_s[i]),     32'(e_s[i]));
      check($sformatf("u%0d out_ch", i),    32'(o_ch[i]),    32'(e_ch[i]));
      check($sformatf("u%0d out_ovf", i),   32'(o_ovf[i]),   32'(e_ovf[i]));
    end
  endtask

  task automatic cycle(input bit v, input bit st, input int ch, input logic [15:0] wv,
                       input bit clr);
    @(negedge clk);
    in_valid = v;
    in_start = st;
    in_ch    = 5'(ch);
    w        = wv;
    clear    = clr;
    for (int i = 0; i < 4; i++) model_step(i, v, st, ch, int'($signed(wv)), clr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 0, 16'h0000, 1'b0);
  endtask

  initial begin
    int ch;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
    idle_cycle();

    // ch 3, terms 1..8
    for (int k = 1; k <= 8; k++) cycle(1'b1, k == 1, 3, 16'(k), 1'b0);
    check("tp1 out_valid", 32'(o_valid[0]), 32'd1);
    check("tp1 S", 32'(o_s[0]), 32'd36);
    idle_cycle();

    // ch 0 and ch 31 interleaved
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, k == 0, 0, 16'h0100, 1'b0);
      if (k == 7) check("ilv ch0 S", 32'(o_s[0]), 32'h0800);
      cycle(1'b1, k == 0, 31, 16'hFFFF, 1'b0);
      if (k == 7) check("ilv ch31 S", 32'(o_s[0]), 32'hFFF8);
    end
    idle_cycle();

    // ch 5 overflow
    cycle(1'b1, 1'b1, 5, 16'h7000, 1'b0);
    cycle(1'b1, 1'b0, 5, 16'h7000, 1'b0);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 5, 16'h0000, 1'b0);
    check("ovf wrap S", 32'(o_s[0]), 32'hE000);
    check("ovf sat S", 32'(o_s[1]), 32'h7FFF);
    check("ovf sat flag", 32'(o_ovf[1]), 32'd1);
    idle_cycle();

    // ch 2 restart mid-sum
    for (int k = 0; k < 4; k++) cycle(1'b1, k == 0, 2, 16'd1, 1'b0);
    cycle(1'b1, 1'b1, 2, 16'd10, 1'b0);
    check("restart seq_err", 32'(o_err[0]), 32'd1);
    for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 2, 16'd1, 1'b0);
    check("restart S", 32'(o_s[0]), 32'd17);
    idle_cycle();

    // ch 7 clear mid-sum
    for (int k = 0; k < 5; k++) cycle(1'b1, k == 0, 7, 16'd3, 1'b0);
    cycle(1'b1, 1'b0, 7, 16'd3, 1'b1);
    idle_cycle();
    for (int k = 0; k < 8; k++) cycle(1'b1, k == 0, 7, 16'd2, 1'b0);
    check("clear S", 32'(o_s[0]), 32'd16);

    // full-rate single-term sums
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, k, 16'($urandom), 1'b0);

    // mid-sum asynchronous reset
    for (int k = 0; k < 4; k++) cycle(1'b1, k == 0, 9, 16'd5, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) idle_cycle();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 1) == 0) ch = $urandom_range(0, 3);
      else                           ch = $urandom_range(16, 31);
      cycle($urandom_range(0, 99) < 85, $urandom_range(0, 5) == 0, ch,
            ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 2);
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
